wu_stats_counter: RTL and testbench
===================================

Name: wu_stats_counter

Overview:
Parametrised, multi-channel successor to the single-channel wake-up statistics counter.
- For each signal-generator trigger it opens a programmable detection window on every channel.
- Per channel it classifies wake-up edges as true positive, false positive or missed, and measures the trigger-to-wake latency: last, min and max.
- A snapshot mechanism gives the host a coherent readout while counting continues.
- Sits between the trigger generator / chip wake-up pins and the host wire-out endpoints.

Parameters:
N_CH, 2, number of wake-up input channels (>=1)
CNT_W, 20, width of event counters
LAT_W, 32, width of latency values and window length
SYNC_STAGES, 2, synchroniser flops on each asynchronous wake_up input (>=2)

Ports:
clki  in  1  system clock
reset  in  1  synchronous, active-high reset
trig  in  1  trigger to signal generator, synchronous to clki
wake_up  in  N_CH  asynchronous wake-up pins from chip
win_len  in  LAT_W  detection window length in clki cycles; 0 treated as 1
snap  in  1  level; a rising edge copies live statistics to shadow registers
sel  in  max(1,$clog2(N_CH))  channel select for readout
rd_total  out  CNT_W  shadow trigger count (shared by all channels)
rd_tp  out  CNT_W  shadow TP count, channel sel
rd_fp  out  CNT_W  shadow FP count, channel sel
rd_missed  out  CNT_W  shadow missed count, channel sel
rd_lat_last  out  LAT_W  shadow last latency, channel sel
rd_lat_min  out  LAT_W  shadow min latency, channel sel
rd_lat_max  out  LAT_W  shadow max latency, channel sel
busy  out  N_CH  channel window open

Behaviour:
- Edge detect:
  - trig: one register stage; trig_edge asserts for one cycle.
  - wake_up[i]: SYNC_STAGES flops, then one edge register; wk_edge[i] asserts for one cycle.
  - For a raw rise D cycles after the raw trig rise, reported latency = D + SYNC_STAGES.
- Per-channel FSM, states IDLE and WINDOW, elapsed counter e (LAT_W).
  - IDLE, wk_edge: fp++.
  - IDLE, trig_edge: go to WINDOW, e<=1.
  - WINDOW, wk_edge with e<=win_len: tp++, lat_last<=e, min/max update, go to IDLE.
  - WINDOW, no edge, e==win_len: missed++, go to IDLE.
  - WINDOW, otherwise: e++.
- Window boundaries: latency win_len counts as TP. An edge at latency win_len+1 counts as missed, and the edge itself counts as FP.
- Shared total++ on every trig_edge.
- Simultaneous events, same cycle:
  - wk_edge is first resolved against the old state: IDLE gives FP, WINDOW gives TP.
  - trig_edge then opens a fresh window with e<=1.
  - trig_edge while WINDOW with no wk_edge: the old window counts as missed, and a new window opens.
- busy[i] = (state==WINDOW).
- Arithmetic:
  - All counters saturate at all-ones and never wrap.
  - lat_min resets to all-ones; lat_max resets to 0.
  - win_len is sampled every cycle. A decrease below the current e closes the window as missed on the next cycle.
- Snapshot:
  - On a snap rising edge, all live values of all channels plus total are copied to shadow registers in one cycle.
  - Events in the snapshot cycle land in live counters only.
  - rd_* are a combinational mux of shadow registers by sel; sel>=N_CH reads channel 0.
- Reset:
  - All FSMs go to IDLE, all counters and shadows go to 0, min and shadow min go to all-ones, synchroniser and edge registers clear, busy=0.
  - Reset mid-window discards the window with no missed count.
  - The first trig_edge detected after reset deasserts starts a window normally.

Decomposition:
- Package wu_stats_pkg holds:
  - the state enum (IDLE, WINDOW)
  - a saturating-increment function parameterised by width
  - a LAT_INIT_MIN constant (all-ones)
- Sub-module wu_stats_ch: one channel containing synchroniser, edge detect, FSM, live and shadow registers. It is instantiated N_CH times by a generate loop.
- The top holds the trig edge detect, total counter, snap edge detect and readout mux.

Test Plan:
1. Reset, win_len=100, trig rise, wake_up[0] rise 10 cycles later, snap, sel=0 -> total=1, tp=1, fp=0, missed=0, lat_last=lat_min=lat_max=12.
2. win_len=50, trig, no wake for 60 cycles, snap -> missed=1, tp=0, busy[0] low 50 cycles after trig_edge; channel 1 identical.
3. Five wake_up[1] pulses with no trig, snap, sel=1 -> fp=5, total=0; channel 0 unchanged.
4. win_len=20: wake at latency exactly 20 -> tp=1; next trig, wake at latency 21 -> missed=1 and fp=1; win_len=0 with wake at latency 1 -> tp.
5. CNT_W=4, 20 FP edges -> fp=15 (saturated). Trig during open window with no wake -> missed increments by 1, new window open (busy=1).
6. Reset asserted mid-window after 3 TPs -> all rd_*=0 except rd_lat_min=all-ones, busy=0. Then trig plus wake at latency 7 -> tp=1, lat_min=lat_max=7.

Source files
------------

// File: rtl/wu_stats_counter_pkg.sv
// Shared definitions for the wake-up statistics counter.
//   - ch_state_e   : per-channel FSM state (IDLE / WINDOW)
//   - SAT_W        : working width of the generic saturating increment
//   - LAT_INIT_MIN : all-ones seed for the running minimum latency
//   - sat_inc()    : saturating +1; the width is a run-time argument so one
//                    function serves counters and latency values alike
package wu_stats_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_WINDOW = 1'b1
  } ch_state_e;

  localparam int SAT_W = 64;

  localparam logic [SAT_W-1:0] LAT_INIT_MIN = {SAT_W{1'b1}};

  // Increment v, saturating at the all-ones value of a w-bit field.
  // v must be zero-extended by the caller; the caller keeps the low w bits.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v, input int w);
    logic [SAT_W-1:0] lim;
    lim = {SAT_W{1'b1}} >> (SAT_W - w);
    if (v >= lim) begin
      return lim;
    end else begin
      return v + {{(SAT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/wu_stats_counter_if.sv
// Host / trigger-side bus of the wake-up statistics counter.
//   trig, wake_up, win_len, snap, sel : stimulus and readout control
//   rd_*                              : shadow statistics of channel sel
//   busy                              : per-channel "window open"
// master = host/generator side, slave = counter.
interface wu_stats_counter_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 20,
  parameter int LAT_W = 32
);
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             trig;
  logic [N_CH-1:0]  wake_up;
  logic [LAT_W-1:0] win_len;
  logic             snap;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] rd_total;
  logic [CNT_W-1:0] rd_tp;
  logic [CNT_W-1:0] rd_fp;
  logic [CNT_W-1:0] rd_missed;
  logic [LAT_W-1:0] rd_lat_last;
  logic [LAT_W-1:0] rd_lat_min;
  logic [LAT_W-1:0] rd_lat_max;
  logic [N_CH-1:0]  busy;

  modport master (
    output trig, wake_up, win_len, snap, sel,
    input  rd_total, rd_tp, rd_fp, rd_missed, rd_lat_last, rd_lat_min, rd_lat_max, busy
  );

  modport slave (
    input  trig, wake_up, win_len, snap, sel,
    output rd_total, rd_tp, rd_fp, rd_missed, rd_lat_last, rd_lat_min, rd_lat_max, busy
  );

endinterface

// File: rtl/wu_stats_counter_ch.sv
// One wake-up channel: synchroniser + edge detect on the asynchronous pin,
// IDLE/WINDOW classification FSM, live statistics and their snapshot copy.
//   clki, reset   : clock, synchronous active-high reset
//   wake_up_i     : raw asynchronous wake-up pin
//   trig_edge_i   : one-cycle trigger pulse from the top
//   snap_edge_i   : one-cycle snapshot pulse from the top
//   win_len_i     : window length (0 behaves as 1)
//   busy_o        : window open
//   sh_*_o        : shadow tp/fp/missed counts and last/min/max latency
module wu_stats_ch
  import wu_stats_pkg::*;
#(
  parameter int CNT_W       = 20,
  parameter int LAT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clki,
  input  logic             reset,
  input  logic             wake_up_i,
  input  logic             trig_edge_i,
  input  logic             snap_edge_i,
  input  logic [LAT_W-1:0] win_len_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] sh_tp_o,
  output logic [CNT_W-1:0] sh_fp_o,
  output logic [CNT_W-1:0] sh_missed_o,
  output logic [LAT_W-1:0] sh_last_o,
  output logic [LAT_W-1:0] sh_min_o,
  output logic [LAT_W-1:0] sh_max_o
);

  localparam logic [LAT_W-1:0] LAT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0] LAT_MINR = LAT_INIT_MIN[LAT_W-1:0];

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    logic [SAT_W-1:0] t;
    t = sat_inc({{(SAT_W-CNT_W){1'b0}}, v}, CNT_W);
    return t[CNT_W-1:0];
  endfunction

  function automatic logic [LAT_W-1:0] lat_inc(input logic [LAT_W-1:0] v);
    logic [SAT_W-1:0] t;
    t = sat_inc({{(SAT_W-LAT_W){1'b0}}, v}, LAT_W);
    return t[LAT_W-1:0];
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   wk_q;
  logic                   wk_edge_s;
  logic [LAT_W-1:0]       win_eff_s;

  ch_state_e        state_q, state_d;
  logic [LAT_W-1:0] e_q, e_d;
  logic             tp_ev_s, fp_ev_s, ms_ev_s;

  logic [CNT_W-1:0] tp_q, tp_d, fp_q, fp_d, ms_q, ms_d;
  logic [LAT_W-1:0] last_q, last_d, min_q, min_d, max_q, max_d;

  logic [CNT_W-1:0] sh_tp_q, sh_fp_q, sh_ms_q;
  logic [LAT_W-1:0] sh_last_q, sh_min_q, sh_max_q;

  // Synchroniser chain followed by the edge register.
  always_ff @(posedge clki) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      wk_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], wake_up_i};
      wk_q   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign wk_edge_s = sync_q[SYNC_STAGES-1] & ~wk_q;

  // Effective window length and event classification against the current state.
  always_comb begin
    win_eff_s = (win_len_i == {LAT_W{1'b0}}) ? LAT_ONE : win_len_i;
    // A wake edge inside the window is a hit; an edge outside any valid window is a false positive.
    tp_ev_s = (state_q == ST_WINDOW) & wk_edge_s & (e_q <= win_eff_s);
    fp_ev_s = wk_edge_s & ~tp_ev_s;
    // The window is lost when it expires, when it is re-triggered, or when
    // a shrunk win_len leaves an edge arriving past the new limit.
    ms_ev_s = (state_q == ST_WINDOW) & ~tp_ev_s &
              (wk_edge_s | trig_edge_i | (e_q >= win_eff_s));
  end

  // FSM next state and elapsed-cycle counter.
  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    case (state_q)
      ST_IDLE: begin
        if (trig_edge_i) begin
          state_d = ST_WINDOW;
          e_d     = LAT_ONE;
        end else begin
          state_d = ST_IDLE;
          e_d     = e_q;
        end
      end
      ST_WINDOW: begin
        if (trig_edge_i) begin
          // Old window is resolved above; a fresh one starts here.
          state_d = ST_WINDOW;
          e_d     = LAT_ONE;
        end else if (tp_ev_s || ms_ev_s) begin
          state_d = ST_IDLE;
          e_d     = e_q;
        end else begin
          state_d = ST_WINDOW;
          e_d     = lat_inc(e_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        e_d     = e_q;
      end
    endcase
  end

  // Live statistics next values.
  always_comb begin
    tp_d   = tp_ev_s ? cnt_inc(tp_q) : tp_q;
    fp_d   = fp_ev_s ? cnt_inc(fp_q) : fp_q;
    ms_d   = ms_ev_s ? cnt_inc(ms_q) : ms_q;
    last_d = tp_ev_s ? e_q : last_q;
    min_d  = (tp_ev_s && (e_q < min_q)) ? e_q : min_q;
    max_d  = (tp_ev_s && (e_q > max_q)) ? e_q : max_q;
  end

  // FSM state and live statistics registers.
  always_ff @(posedge clki) begin
    if (reset) begin
      state_q <= ST_IDLE;
      e_q     <= {LAT_W{1'b0}};
      tp_q    <= {CNT_W{1'b0}};
      fp_q    <= {CNT_W{1'b0}};
      ms_q    <= {CNT_W{1'b0}};
      last_q  <= {LAT_W{1'b0}};
      min_q   <= LAT_MINR;
      max_q   <= {LAT_W{1'b0}};
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      tp_q    <= tp_d;
      fp_q    <= fp_d;
      ms_q    <= ms_d;
      last_q  <= last_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

  // Shadow copy of the pre-update live values on a snapshot pulse.
  always_ff @(posedge clki) begin
    if (reset) begin
      sh_tp_q   <= {CNT_W{1'b0}};
      sh_fp_q   <= {CNT_W{1'b0}};
      sh_ms_q   <= {CNT_W{1'b0}};
      sh_last_q <= {LAT_W{1'b0}};
      sh_min_q  <= LAT_MINR;
      sh_max_q  <= {LAT_W{1'b0}};
    end else if (snap_edge_i) begin
      sh_tp_q   <= tp_q;
      sh_fp_q   <= fp_q;
      sh_ms_q   <= ms_q;
      sh_last_q <= last_q;
      sh_min_q  <= min_q;
      sh_max_q  <= max_q;
    end else begin
      sh_tp_q   <= sh_tp_q;
      sh_fp_q   <= sh_fp_q;
      sh_ms_q   <= sh_ms_q;
      sh_last_q <= sh_last_q;
      sh_min_q  <= sh_min_q;
      sh_max_q  <= sh_max_q;
    end
  end

  assign busy_o      = (state_q == ST_WINDOW);
  assign sh_tp_o     = sh_tp_q;
  assign sh_fp_o     = sh_fp_q;
  assign sh_missed_o = sh_ms_q;
  assign sh_last_o   = sh_last_q;
  assign sh_min_o    = sh_min_q;
  assign sh_max_o    = sh_max_q;

endmodule

// File: rtl/wu_stats_counter.sv
// Multi-channel wake-up statistics counter (top).
//   clki, reset : clock, synchronous active-high reset
//   bus (slave) : trig/wake_up/win_len/snap/sel in; rd_* shadow readout and
//                 per-channel busy out
// Holds the trigger and snapshot edge detectors, the shared trigger count
// and the readout mux; per-channel work lives in wu_stats_ch.
module wu_stats_counter
  import wu_stats_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 20,
  parameter int LAT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic               clki,
  input logic               reset,
  wu_stats_counter_if.slave bus
);

  localparam int              SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [SEL_W:0]  N_CH_V = (SEL_W+1)'(N_CH);

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    logic [SAT_W-1:0] t;
    t = sat_inc({{(SAT_W-CNT_W){1'b0}}, v}, CNT_W);
    return t[CNT_W-1:0];
  endfunction

  logic             trig_q, snap_q;
  logic             trig_edge_s, snap_edge_s;
  logic [CNT_W-1:0] total_q, total_d, sh_total_q;
  logic [SEL_W-1:0] idx_s;
  logic [N_CH-1:0]  busy_s;

  logic [CNT_W-1:0] sh_tp_s   [N_CH];
  logic [CNT_W-1:0] sh_fp_s   [N_CH];
  logic [CNT_W-1:0] sh_ms_s   [N_CH];
  logic [LAT_W-1:0] sh_last_s [N_CH];
  logic [LAT_W-1:0] sh_min_s  [N_CH];
  logic [LAT_W-1:0] sh_max_s  [N_CH];

  // trig is already synchronous, so a single history flop suffices.
  assign trig_edge_s = bus.trig & ~trig_q;
  assign snap_edge_s = bus.snap & ~snap_q;
  assign total_d     = trig_edge_s ? cnt_inc(total_q) : total_q;

  // Edge-detect history, shared trigger count and its shadow.
  always_ff @(posedge clki) begin
    if (reset) begin
      trig_q     <= 1'b0;
      snap_q     <= 1'b0;
      total_q    <= {CNT_W{1'b0}};
      sh_total_q <= {CNT_W{1'b0}};
    end else begin
      trig_q     <= bus.trig;
      snap_q     <= bus.snap;
      total_q    <= total_d;
      sh_total_q <= snap_edge_s ? total_q : sh_total_q;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    wu_stats_ch #(
      .CNT_W       (CNT_W),
      .LAT_W       (LAT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clki        (clki),
      .reset       (reset),
      .wake_up_i   (bus.wake_up[g]),
      .trig_edge_i (trig_edge_s),
      .snap_edge_i (snap_edge_s),
      .win_len_i   (bus.win_len),
      .busy_o      (busy_s[g]),
      .sh_tp_o     (sh_tp_s[g]),
      .sh_fp_o     (sh_fp_s[g]),
      .sh_missed_o (sh_ms_s[g]),
      .sh_last_o   (sh_last_s[g]),
      .sh_min_o    (sh_min_s[g]),
      .sh_max_o    (sh_max_s[g])
    );
  end

  // Readout mux; an out-of-range select falls back to channel 0.
  always_comb begin
    if ({1'b0, bus.sel} < N_CH_V) begin
      idx_s = bus.sel;
    end else begin
      idx_s = {SEL_W{1'b0}};
    end
    bus.rd_total    = sh_total_q;
    bus.rd_tp       = sh_tp_s[idx_s];
    bus.rd_fp       = sh_fp_s[idx_s];
    bus.rd_missed   = sh_ms_s[idx_s];
    bus.rd_lat_last = sh_last_s[idx_s];
    bus.rd_lat_min  = sh_min_s[idx_s];
    bus.rd_lat_max  = sh_max_s[idx_s];
  end

  assign bus.busy = busy_s;

endmodule

// File: tb/tb_wu_stats_counter.sv
// Self-checking bench for wu_stats_counter (N_CH=2, CNT_W=4 so saturation
// is reachable quickly). Single-trigger experiments come from a vector
// table whose expectations pass through a scoreboard queue; multi-cycle
// corner cases are hand-written sequences.
module tb_wu_stats_counter;

  localparam int          N_CH  = 2;
  localparam int          CNT_W = 4;
  localparam int          LAT_W = 32;
  localparam logic [31:0] MX    = 32'hFFFF_FFFF;

  typedef struct {
    int          tp;
    int          fp;
    int          ms;
    logic [31:0] last;
    logic [31:0] mn;
    logic [31:0] mx;
  } chexp_t;

  typedef struct {
    bit         rst;
    int         win;
    int         lat;    // reported latency of the wake edge, -1 = no wake
    logic [1:0] mask;
    int         total;
    chexp_t     c0;
    chexp_t     c1;
  } vec_t;

  logic clki = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t vecs[6];
  vec_t sb[$];
  vec_t ev;

  wu_stats_counter_if #(.N_CH(N_CH), .CNT_W(CNT_W), .LAT_W(LAT_W)) bus ();

  wu_stats_counter #(
    .N_CH(N_CH), .CNT_W(CNT_W), .LAT_W(LAT_W), .SYNC_STAGES(2)
  ) dut (
    .clki  (clki),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clki = ~clki;

  task automatic tick();
    @(posedge clki);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.trig = 1'b0;
    bus.wake_up = 2'b00;
    bus.snap = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic take_snap();
    bus.snap = 1'b1;
    tick();
    bus.snap = 1'b0;
    tick();
  endtask

  // One trigger, optional wake edge at reported latency lat on channels in mask.
  // Input changes before tick j are sampled at edge j; trig is sampled at edge 0.
  task automatic run_trial(input int win, input int lat, input logic [1:0] mask);
    int start;
    bus.win_len = win;
    start = (lat >= 0 && lat < 2) ? lat - 2 : 0;
    for (int j = start; j <= win + 6; j++) begin
      bus.trig = (j == 0);
      if (lat >= 0 && j == lat - 2) bus.wake_up = mask;
      tick();
    end
    bus.trig = 1'b0;
    bus.wake_up = 2'b00;
    repeat (4) tick();
  endtask

  task automatic chk_ch(input int c, input chexp_t e);
    bus.sel = c[0];
    #1;
    chk($sformatf("tp_ch%0d", c),   bus.rd_tp,       e.tp);
    chk($sformatf("fp_ch%0d", c),   bus.rd_fp,       e.fp);
    chk($sformatf("miss_ch%0d", c), bus.rd_missed,   e.ms);
    chk($sformatf("last_ch%0d", c), bus.rd_lat_last, e.last);
    chk($sformatf("min_ch%0d", c),  bus.rd_lat_min,  e.mn);
    chk($sformatf("max_ch%0d", c),  bus.rd_lat_max,  e.mx);
  endtask

  task automatic pulses(input logic [1:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      bus.wake_up = mask;
      repeat (2) tick();
      bus.wake_up = 2'b00;
      repeat (2) tick();
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 100, 12, 2'b01, 1, '{1, 0, 0, 32'd12, 32'd12, 32'd12}, '{0, 0, 1, 32'd0, MX, 32'd0}};
    vecs[1] = '{1'b1, 50, -1, 2'b00, 1, '{0, 0, 1, 32'd0, MX, 32'd0}, '{0, 0, 1, 32'd0, MX, 32'd0}};
    vecs[2] = '{1'b1, 20, 20, 2'b11, 1, '{1, 0, 0, 32'd20, 32'd20, 32'd20}, '{1, 0, 0, 32'd20, 32'd20, 32'd20}};
    vecs[3] = '{1'b0, 20, 21, 2'b11, 2, '{1, 1, 1, 32'd20, 32'd20, 32'd20}, '{1, 1, 1, 32'd20, 32'd20, 32'd20}};
    vecs[4] = '{1'b0, 0, 1, 2'b11, 3, '{2, 1, 1, 32'd1, 32'd1, 32'd20}, '{2, 1, 1, 32'd1, 32'd1, 32'd20}};
    vecs[5] = '{1'b0, 100, 40, 2'b01, 4, '{3, 1, 1, 32'd40, 32'd1, 32'd40}, '{2, 1, 2, 32'd1, 32'd1, 32'd20}};

    bus.trig = 1'b0;
    bus.wake_up = 2'b00;
    bus.snap = 1'b0;
    bus.sel = 1'b0;
    bus.win_len = 32'd100;
    reset = 1'b0;
    do_reset();

    // Reset state of the readout.
    chk("rst_total", bus.rd_total, 0);
    chk("rst_min", bus.rd_lat_min, MX);
    chk("rst_max", bus.rd_lat_max, 0);
    chk("rst_busy", bus.busy, 0);

    // Table-driven single-trigger experiments.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].rst) do_reset();
      sb.push_back(vecs[i]);
      run_trial(vecs[i].win, vecs[i].lat, vecs[i].mask);
      take_snap();
      ev = sb.pop_front();
      chk($sformatf("total_v%0d", i), bus.rd_total, ev.total);
      chk($sformatf("busy_v%0d", i), bus.busy, 0);
      chk_ch(0, ev.c0);
      chk_ch(1, ev.c1);
    end

    // Window closes exactly win_len cycles after the trigger edge.
    do_reset();
    bus.win_len = 32'd50;
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    chk("busy_open", bus.busy, 2'b11);
    repeat (49) tick();
    chk("busy_last", bus.busy, 2'b11);
    tick();
    chk("busy_closed", bus.busy, 2'b00);

    // False positives without any trigger.
    do_reset();
    pulses(2'b10, 5);
    take_snap();
    bus.sel = 1'b1;
    #1;
    chk("fp5_ch1", bus.rd_fp, 5);
    chk("fp5_total", bus.rd_total, 0);
    bus.sel = 1'b0;
    #1;
    chk("fp5_ch0_fp", bus.rd_fp, 0);
    chk("fp5_ch0_tp", bus.rd_tp, 0);

    // Counter saturation, then retrigger inside an open window.
    do_reset();
    pulses(2'b01, 20);
    take_snap();
    bus.sel = 1'b0;
    #1;
    chk("fp_sat", bus.rd_fp, 15);
    bus.win_len = 32'd100;
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    repeat (10) tick();
    chk("busy_first", bus.busy, 2'b11);
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    tick();
    chk("busy_retrig", bus.busy, 2'b11);
    take_snap();
    chk("retrig_missed", bus.rd_missed, 1);
    chk("retrig_total", bus.rd_total, 2);
    repeat (110) tick();
    chk("retrig_timeout_busy", bus.busy, 2'b00);
    chk("shadow_hold", bus.rd_missed, 1);
    take_snap();
    chk("retrig_missed2", bus.rd_missed, 2);

    // Reset in the middle of a window after several hits.
    do_reset();
    for (int k = 0; k < 3; k++) run_trial(100, 5, 2'b01);
    take_snap();
    chk("pre_rst_tp", bus.rd_tp, 3);
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    repeat (3) tick();
    chk("pre_rst_busy", bus.busy, 2'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_busy", bus.busy, 2'b00);
    chk("mid_rst_tp", bus.rd_tp, 0);
    chk("mid_rst_total", bus.rd_total, 0);
    chk("mid_rst_min", bus.rd_lat_min, MX);
    chk("mid_rst_last", bus.rd_lat_last, 0);
    take_snap();
    chk("mid_rst_missed", bus.rd_missed, 0);
    run_trial(100, 7, 2'b01);
    take_snap();
    chk("post_rst_tp", bus.rd_tp, 1);
    chk("post_rst_min", bus.rd_lat_min, 7);
    chk("post_rst_max", bus.rd_lat_max, 7);
    chk("post_rst_missed", bus.rd_missed, 0);
    chk("post_rst_total", bus.rd_total, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
